// File: rtl/writeback_queue.sv
// writeback_queue: in-order FIFO of load/ALU results issuing one register-file write per cycle,
// with pending-write lookup for two decode read ports.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     wb_enable,
    input  logic [ADDR_W-1:0]        Read_register1,
    input  logic [ADDR_W-1:0]        Read_register2,
    output logic                     pending1,
    output logic                     pending2,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        Write_register,
    output logic [DATA_W-1:0]        Write_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     head, tail, alu_idx;
    logic              mem_push, alu_push, pop, p1, p2;

    // Readiness uses registered occupancy only; a same-cycle pop frees nothing.
    assign mem_ready = count < CW'(DEPTH);
    assign alu_ready = (count <= CW'(DEPTH - 2)) | ((count == CW'(DEPTH - 1)) & ~mem_valid);
    assign mem_push  = mem_valid & mem_ready & (mem_rd != '0);
    assign alu_push  = alu_valid & alu_ready & (alu_rd != '0);
    assign pop       = (count != '0) & wb_enable;
    assign alu_idx   = tail + PW'(mem_push);

    always_comb begin
        p1 = RegWrite & (Write_register == Read_register1);
        p2 = RegWrite & (Write_register == Read_register2);
        for (int i = 0; i < DEPTH; i++) begin
            p1 = p1 | (vld[i] & (rd_q[i] == Read_register1));
            p2 = p2 | (vld[i] & (rd_q[i] == Read_register2));
        end
        pending1 = p1 & (Read_register1 != '0);
        pending2 = p2 & (Read_register2 != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            vld            <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_data     <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                vld[head]      <= 1'b0;
                head           <= head + PW'(1);
                Write_register <= rd_q[head];
                Write_data     <= data_q[head];
            end
            if (mem_push) begin
                rd_q[tail]   <= mem_rd;
                data_q[tail] <= mem_data;
                vld[tail]    <= 1'b1;
            end
            if (alu_push) begin
                rd_q[alu_idx]   <= alu_rd;
                data_q[alu_idx] <= alu_data;
                vld[alu_idx]    <= 1'b1;
            end
            tail  <= tail + PW'(mem_push) + PW'(alu_push);
            count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed and random stimulus checked against a queue-based reference model.
module tb_writeback_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0, alu_valid = 1'b0, wb_enable = 1'b0;
    logic [4:0]  mem_rd = '0, alu_rd = '0, Read_register1 = '0, Read_register2 = '0;
    logic [31:0] mem_data = '0, alu_data = '0;
    logic        mem_ready, alu_ready, pending1, pending2, RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [2:0]  count;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_rw = 1'b0;
    logic [4:0]  m_wr = '0;
    logic [31:0] m_wd = '0;
    int          checks = 0, errors = 0;

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .wb_enable(wb_enable), .Read_register1(Read_register1), .Read_register2(Read_register2),
        .pending1(pending1), .pending2(pending2), .RegWrite(RegWrite),
        .Write_register(Write_register), .Write_data(Write_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic mpend(input logic [4:0] r);
        logic hit;
        hit = m_rw && (m_wr == r);
        foreach (q[i]) hit = hit | (q[i].rd == r);
        return (r != 0) && hit;
    endfunction

    task automatic cyc(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic wbe, input logic [4:0] r1, input logic [4:0] r2);
        logic e_mr, e_ar;
        int   fr;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        wb_enable = wbe; Read_register1 = r1; Read_register2 = r2;
        #4;
        fr   = DEPTH - q.size();
        e_mr = fr >= 1;
        e_ar = (fr >= 2) || (fr == 1 && !mv);
        chk("count", 32'(count), 32'(q.size()));
        chk("mem_ready", 32'(mem_ready), 32'(e_mr));
        chk("alu_ready", 32'(alu_ready), 32'(e_ar));
        chk("pending1", 32'(pending1), 32'(mpend(r1)));
        chk("pending2", 32'(pending2), 32'(mpend(r2)));
        chk("RegWrite", 32'(RegWrite), 32'(m_rw));
        chk("Write_register", 32'(Write_register), 32'(m_wr));
        chk("Write_data", Write_data, m_wd);
        @(posedge clk);
        if (q.size() > 0 && wbe) begin
            m_rw = 1'b1; m_wr = q[0].rd; m_wd = q[0].d;
            void'(q.pop_front());
        end else m_rw = 1'b0;
        if (mv && e_mr && mrd != 0) q.push_back('{rd: mrd, d: md});
        if (av && e_ar && ard != 0) q.push_back('{rd: ard, d: ad});
        #1;
    endtask

    task automatic idle(input logic wbe, input logic [4:0] r1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, wbe, r1, 5'd0);
    endtask

    initial begin
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_ready", 32'({mem_ready, alu_ready}), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: fill three entries then assert reset between edges
        cyc(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 1'b0, 5'd3, 5'd4);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h6, 1'b0, 5'd6, 5'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd6);
        Read_register1 = 5'd4; Read_register2 = 5'd6;
        #2 reset = 1'b0;
        #1;
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_RegWrite", 32'(RegWrite), 32'd0);
        chk("t1_pending", 32'({pending1, pending2}), 32'd0);
        chk("t1_wr_regs", 32'(Write_register) | Write_data, 32'd0);
        q.delete(); m_rw = 1'b0; m_wr = '0; m_wd = '0;
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // 2: single ALU push, write issues one cycle after acceptance
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd0);
        idle(1'b1, 5'd5);
        chk("t2_RegWrite", 32'(RegWrite), 32'd1);
        chk("t2_wreg", 32'(Write_register), 32'd5);
        chk("t2_wdata", Write_data, 32'hDEADBEEF);
        idle(1'b1, 5'd5);
        idle(1'b1, 5'd5);

        // 3: simultaneous mem+ALU to the same rd, mem first
        cyc(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 5'd0);
        idle(1'b1, 5'd7);
        chk("t3_first", Write_data, 32'h11);
        idle(1'b1, 5'd7);
        chk("t3_second", Write_data, 32'h22);
        idle(1'b1, 5'd7);

        // 4: fill with wb_enable=0, then drain in order
        cyc(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 1'b0, 5'd1, 5'd2);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hA3, 1'b0, 5'd3, 5'd8);
        cyc(1'b1, 5'd8, 32'hA4, 1'b1, 5'd9, 32'hA5, 1'b0, 5'd8, 5'd9);
        chk("t4_full", 32'(count), 32'd4);
        cyc(1'b1, 5'd10, 32'hA6, 1'b1, 5'd11, 32'hA7, 1'b0, 5'd10, 5'd1);
        for (int i = 0; i < 5; i++) idle(1'b1, 5'd8);

        // 5: rd 0 is accepted but never queued
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
        chk("t5_count", 32'(count), 32'd0);
        idle(1'b1, 5'd0);
        chk("t5_RegWrite", 32'(RegWrite), 32'd0);

        // 6: continuous push/pop across pointer wrap
        for (int i = 0; i < 3 * DEPTH; i++)
            cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'(i % 31 + 1), 32'h100 + 32'(i), 1'b1, 5'(i % 31 + 1), 5'd0);
        idle(1'b1, 5'd0);
        idle(1'b1, 5'd0);

        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
